mux_sel_arbiter: RTL and testbench

MUX_SEL_ARBITER -- requirements
Module: mux_sel_arbiter

---
 rtl/mux_sel_arbiter.sv | 104 ++++++++++
 tb/tb_mux_sel_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mux_sel_arbiter.sv
// Two-requester arbiter driving the select of a downstream 2:1 mux.
// Round-robin on ties, with a bounded hold when both sides are requesting.
module mux_sel_arbiter #(
    parameter int unsigned MAX_HOLD = 4,
    parameter int unsigned CNT_W    = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1,
    output logic s,
    output logic busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_q, last_d;
    logic             gnt0_q, gnt0_d;
    logic             gnt1_q, gnt1_d;
    logic             s_q, s_d;
    logic             busy_q, busy_d;
    logic             hold_at_max;

    // State register; last resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    // Next-state and hold counter; cnt_d defaults to 0 so every entry clears it.
    always_comb begin
        state_d     = state_q;
        cnt_d       = '0;
        hold_at_max = (cnt_q == HOLD_LAST);
        case (state_q)
            IDLE: begin
                if (req0 && req1) state_d = last_q ? G0 : G1;
                else if (req0)    state_d = G0;
                else if (req1)    state_d = G1;
            end
            G0: begin
                if (!req0)            state_d = req1 ? G1 : IDLE;
                else if (hold_at_max) state_d = req1 ? G1 : G0;
                else                  cnt_d   = cnt_q + CNT_W'(1);
            end
            G1: begin
                if (!req1)            state_d = req0 ? G0 : IDLE;
                else if (hold_at_max) state_d = req0 ? G0 : G1;
                else                  cnt_d   = cnt_q + CNT_W'(1);
            end
            default: state_d = IDLE;
        endcase
        last_d = last_q;
        if (state_d == G0) last_d = 1'b0;
        if (state_d == G1) last_d = 1'b1;
    end

    // Output decode from the next state so outputs land on the same edge as the state.
    always_comb begin
        gnt0_d = (state_d == G0);
        gnt1_d = (state_d == G1);
        busy_d = (state_d != IDLE);
        s_d    = s_q;
        if (state_d == G0) s_d = 1'b0;
        if (state_d == G1) s_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt0_q <= 1'b0;
            gnt1_q <= 1'b0;
            s_q    <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            gnt0_q <= gnt0_d;
            gnt1_q <= gnt1_d;
            s_q    <= s_d;
            busy_q <= busy_d;
        end
    end

    assign gnt0 = gnt0_q;
    assign gnt1 = gnt1_q;
    assign s    = s_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Scoreboard bench for mux_sel_arbiter: default MAX_HOLD=4 instance plus a MAX_HOLD=1 instance.
module tb_mux_sel_arbiter;

    logic clk = 1'b0;
    logic rst;
    logic req0, req1, gnt0, gnt1, s, busy;
    logic r0b, r1b, g0b, g1b, sb, busyb;

    int tests_run    = 0;
    int tests_failed = 0;

    // Expected {gnt0, gnt1, s, busy}
    logic [3:0] exp_q[$];
    localparam logic [3:0] E_G0 = 4'b1001;
    localparam logic [3:0] E_G1 = 4'b0111;
    localparam logic [3:0] E_I0 = 4'b0000;
    localparam logic [3:0] E_I1 = 4'b0010;

    always #5 clk = ~clk;

    mux_sel_arbiter #(.MAX_HOLD(4), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1),
        .gnt0(gnt0), .gnt1(gnt1), .s(s), .busy(busy)
    );

    mux_sel_arbiter #(.MAX_HOLD(1), .CNT_W(1)) dut1 (
        .clk(clk), .rst(rst), .req0(r0b), .req1(r1b),
        .gnt0(g0b), .gnt1(g1b), .s(sb), .busy(busyb)
    );

    // Mutual exclusion of grants on both instances, over every test.
    always @(negedge clk) begin
        if ((gnt0 && gnt1) || (g0b && g1b)) begin
            tests_failed++;
            $display("FAIL mutex: gnt0/gnt1=%b%b gnt0b/gnt1b=%b%b required not both high",
                     gnt0, gnt1, g0b, g1b);
        end
    end

    // Drive one cycle of requests and queue the outputs expected after the edge.
    task automatic step(input logic r0, input logic r1, input logic [3:0] e);
        req0 = r0;
        req1 = r1;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] e, got;
        req0 = 1'b1; req1 = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b1;
        exp_q.push_back(E_I0);
        #1;
        got = {gnt0, gnt1, s, busy};
        e = exp_q.pop_front();
        tests_run++;
        if (got !== e) begin
            tests_failed++;
            $display("FAIL reset: got %b required %b", got, e);
        end
        got = {g0b, g1b, sb, busyb};
        tests_run++;
        if (got !== E_I0) begin
            tests_failed++;
            $display("FAIL reset_mh1: got %b required %b", got, E_I0);
        end
        req0 = 1'b0; req1 = 1'b0;
        #1;
        rst = 1'b0;
    endtask

    task automatic test_rotation();
        logic [3:0] e, got;
        apply_reset();
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b1, ((i / 4) % 2 == 0) ? E_G0 : E_G1);
            got = {gnt0, gnt1, s, busy};
            e = exp_q.pop_front();
            tests_run++;
            if (got !== e) begin
                tests_failed++;
                $display("FAIL rotation cycle %0d: got %b required %b", i + 1, got, e);
            end
        end
    endtask

    task automatic test_single_hold();
        logic [3:0] e, got;
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, E_G0);
            got = {gnt0, gnt1, s, busy};
            e = exp_q.pop_front();
            tests_run++;
            if (got !== e) begin
                tests_failed++;
                $display("FAIL single_hold cycle %0d: got %b required %b", i + 1, got, e);
            end
        end
    endtask

    // G0 -> G1 handoff, idle with s held at 1, then back to G0; ties from idle follow last.
    task automatic test_handoff_idle();
        logic [3:0] e, got;
        logic [1:0] r_tab [8];
        logic [3:0] e_tab [8];
        apply_reset();
        r_tab = '{2'b10, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 2'b11, 2'b00};
        e_tab = '{E_G0,  E_G1,  E_I1,  E_I1,  E_G0,  E_I0,  E_G1,  E_I1};
        for (int i = 0; i < 8; i++) begin
            step(r_tab[i][1], r_tab[i][0], e_tab[i]);
            got = {gnt0, gnt1, s, busy};
            e = exp_q.pop_front();
            tests_run++;
            if (got !== e) begin
                tests_failed++;
                $display("FAIL handoff_idle step %0d: got %b required %b", i, got, e);
            end
        end
    endtask

    task automatic test_rst_mid_grant();
        logic [3:0] e, got;
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, E_G1);
            got = {gnt0, gnt1, s, busy};
            e = exp_q.pop_front();
            tests_run++;
            if (got !== e) begin
                tests_failed++;
                $display("FAIL rst_mid setup %0d: got %b required %b", i, got, e);
            end
        end
        #1;
        rst = 1'b1;
        exp_q.push_back(E_I0);
        #1;
        got = {gnt0, gnt1, s, busy};
        e = exp_q.pop_front();
        tests_run++;
        if (got !== e) begin
            tests_failed++;
            $display("FAIL rst_mid abort: got %b required %b", got, e);
        end
        req0 = 1'b1; req1 = 1'b1;
        #1;
        rst = 1'b0;
        exp_q.push_back(E_G0);
        @(posedge clk);
        #1;
        got = {gnt0, gnt1, s, busy};
        e = exp_q.pop_front();
        tests_run++;
        if (got !== e) begin
            tests_failed++;
            $display("FAIL rst_mid release: got %b required %b", got, e);
        end
        req0 = 1'b0; req1 = 1'b0;
    endtask

    task automatic test_max_hold1();
        logic [3:0] e, got;
        req0 = 1'b0; req1 = 1'b0;
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            r0b = 1'b1; r1b = 1'b1;
            exp_q.push_back((i % 2 == 0) ? E_G0 : E_G1);
            @(posedge clk);
            #1;
            got = {g0b, g1b, sb, busyb};
            e = exp_q.pop_front();
            tests_run++;
            if (got !== e) begin
                tests_failed++;
                $display("FAIL max_hold1 cycle %0d: got %b required %b", i + 1, got, e);
            end
        end
        r0b = 1'b0; r1b = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        r0b = 1'b0; r1b = 1'b0;
        #12;
        rst = 1'b0;
        test_reset();
        test_rotation();
        test_single_hold();
        test_handoff_idle();
        test_rst_mid_grant();
        test_max_hold1();
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain: %0d left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
